// File: rtl/fpu_cmd_arbiter.sv
// Shares one fpu between core issue (0) and loader (1), round-robin, one command in flight.
// Latency: accept t -> fpu_ready t+1 -> resp pulse one cycle after fpu_valid; reqN_ready only in IDLE.
// Optional BUSY watchdog (aborts with resp_err) when FPU_ARB_TIMEOUT_EN is defined.
module fpu_cmd_arbiter #(
  parameter int OP_W           = 6,
  parameter int REG_W          = 5,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [OP_W-1:0]   req0_op,
  input  logic [REG_W-1:0]  req0_x1,
  input  logic [REG_W-1:0]  req0_x2,
  input  logic [REG_W-1:0]  req0_y,
  input  logic [DATA_W-1:0] req0_data,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [OP_W-1:0]   req1_op,
  input  logic [REG_W-1:0]  req1_x1,
  input  logic [REG_W-1:0]  req1_x2,
  input  logic [REG_W-1:0]  req1_y,
  input  logic [DATA_W-1:0] req1_data,
  output logic              resp0_valid,
  output logic              resp1_valid,
  output logic [DATA_W-1:0] resp_data,
  output logic              resp_cond,
  output logic              resp_err,
  output logic [OP_W-1:0]   fpu_operation,
  output logic [REG_W-1:0]  fpu_x1,
  output logic [REG_W-1:0]  fpu_x2,
  output logic [REG_W-1:0]  fpu_y,
  output logic [DATA_W-1:0] fpu_in_data,
  output logic              fpu_ready,
  input  logic              fpu_valid,
  input  logic [DATA_W-1:0] fpu_out_data,
  input  logic              fpu_cond
);

  typedef struct packed {
    logic [OP_W-1:0]   op;
    logic [REG_W-1:0]  x1;
    logic [REG_W-1:0]  x2;
    logic [REG_W-1:0]  y;
    logic [DATA_W-1:0] data;
  } cmd_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t state_q, state_d;
  cmd_t   cmd0, cmd1, sel_cmd, cmd_q;
  logic   grant;
  logic   accept;
  logic   done;
  logic   tmo;
  logic   tmo_hit;
  logic   owner_q;
  logic   last_grant_q;

  assign cmd0    = {req0_op, req0_x1, req0_x2, req0_y, req0_data};
  assign cmd1    = {req1_op, req1_x1, req1_x2, req1_y, req1_data};
  assign sel_cmd = grant ? cmd1 : cmd0;

  assign fpu_operation = cmd_q.op;
  assign fpu_x1        = cmd_q.x1;
  assign fpu_x2        = cmd_q.x2;
  assign fpu_y         = cmd_q.y;
  assign fpu_in_data   = cmd_q.data;

  assign resp0_valid = (state_q == ST_RESP) && !owner_q;
  assign resp1_valid = (state_q == ST_RESP) &&  owner_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    grant      = 1'b0;
    accept     = 1'b0;
    done       = 1'b0;
    tmo        = 1'b0;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (req0_valid || req1_valid) begin
          // Under contention the requester that did not win last time goes next.
          grant      = (req0_valid && req1_valid) ? ~last_grant_q : req1_valid;
          accept     = 1'b1;
          req0_ready = ~grant;
          req1_ready = grant;
          state_d    = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (fpu_valid) begin
          done    = 1'b1;
          state_d = ST_RESP;
        end else if (tmo_hit) begin
          tmo     = 1'b1;
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd_q        <= '0;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      fpu_ready    <= 1'b0;
      resp_data    <= '0;
      resp_cond    <= 1'b0;
    end else begin
      if (accept) begin
        cmd_q        <= sel_cmd;
        owner_q      <= grant;
        last_grant_q <= grant;
        fpu_ready    <= 1'b1;
      end else if (done || tmo) begin
        fpu_ready    <= 1'b0;
      end
      if (done) begin
        resp_data <= fpu_out_data;
        resp_cond <= fpu_cond;
      end else if (tmo) begin
        resp_data <= '0;
        resp_cond <= 1'b0;
      end
    end
  end

`ifdef FPU_ARB_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CNT_W-1:0] tmo_cnt_q;
  logic             resp_err_q;

  // Counts BUSY cycles that end without fpu_valid; restarts with every accepted command.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_cnt_q <= '0;
    end else if (accept) begin
      tmo_cnt_q <= '0;
    end else if ((state_q == ST_BUSY) && !fpu_valid) begin
      tmo_cnt_q <= tmo_cnt_q + CNT_W'(1);
    end
  end

  assign tmo_hit = (tmo_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp_err_q <= 1'b0;
    end else if (done) begin
      resp_err_q <= 1'b0;
    end else if (tmo) begin
      resp_err_q <= 1'b1;
    end
  end

  assign resp_err = resp_err_q;
`else
  logic unused_timeout_cfg;

  assign tmo_hit            = 1'b0;
  assign resp_err           = 1'b0;
  assign unused_timeout_cfg = |TIMEOUT_CYCLES;
`endif

endmodule

// File: tb/tb_fpu_cmd_arbiter.sv
// Randomized bench for fpu_cmd_arbiter: transaction-level requester/fpu model with round-robin scoreboard.
module tb_fpu_cmd_arbiter;

  localparam logic [5:0] OP_SET  = 6'h01;
  localparam logic [5:0] OP_FADD = 6'h02;

  typedef struct packed {
    logic [5:0]  op;
    logic [4:0]  x1;
    logic [4:0]  x2;
    logic [4:0]  y;
    logic [31:0] data;
  } cmd_t;

  logic        clk, rst;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [5:0]  req0_op, req1_op;
  logic [4:0]  req0_x1, req0_x2, req0_y, req1_x1, req1_x2, req1_y;
  logic [31:0] req0_data, req1_data;
  logic        resp0_valid, resp1_valid, resp_cond, resp_err;
  logic [31:0] resp_data;
  logic [5:0]  fpu_operation;
  logic [4:0]  fpu_x1, fpu_x2, fpu_y;
  logic [31:0] fpu_in_data, fpu_out_data;
  logic        fpu_ready, fpu_valid, fpu_cond;

  fpu_cmd_arbiter #(
    .OP_W(6), .REG_W(5), .DATA_W(32), .TIMEOUT_CYCLES(8)
  ) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_x1(req0_x1), .req0_x2(req0_x2), .req0_y(req0_y), .req0_data(req0_data),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_x1(req1_x1), .req1_x2(req1_x2), .req1_y(req1_y), .req1_data(req1_data),
    .resp0_valid(resp0_valid), .resp1_valid(resp1_valid), .resp_data(resp_data),
    .resp_cond(resp_cond), .resp_err(resp_err),
    .fpu_operation(fpu_operation), .fpu_x1(fpu_x1), .fpu_x2(fpu_x2), .fpu_y(fpu_y),
    .fpu_in_data(fpu_in_data), .fpu_ready(fpu_ready), .fpu_valid(fpu_valid),
    .fpu_out_data(fpu_out_data), .fpu_cond(fpu_cond)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_chk  = 0;
  int   n_pass = 0;
  bit   pend[2];
  cmd_t pend_cmd[2];
  int   last_win;
  int   grant_log[$];
  logic [31:0] exp_data;
  logic        exp_cond;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
  endtask

  task automatic rand_cmd(output cmd_t c);
    c.op   = 6'($urandom);
    c.x1   = 5'($urandom);
    c.x2   = 5'($urandom);
    c.y    = 5'($urandom);
    c.data = $urandom;
  endtask

  task automatic drive_reqs();
    req0_valid = pend[0];
    req1_valid = pend[1];
    {req0_op, req0_x1, req0_x2, req0_y, req0_data} = pend_cmd[0];
    {req1_op, req1_x1, req1_x2, req1_y, req1_data} = pend_cmd[1];
  endtask

  task automatic check_busy(input cmd_t c);
    check_eq("busy_fpu_ready", fpu_ready, 1'b1);
    check_eq("busy_fpu_cmd", {fpu_operation, fpu_x1, fpu_x2, fpu_y, fpu_in_data}, c);
    check_eq("busy_rdy", {req0_ready, req1_ready}, 2'b00);
    check_eq("busy_resp_vld", {resp0_valid, resp1_valid}, 2'b00);
  endtask

  // Called at a negedge while the arbiter is idle; returns at a negedge after the response.
  task automatic one_cmd(input int k, input bit fill0, input bit fill1,
                         input bit fixed_rsp, input logic [31:0] rsp_d, input logic rsp_c);
    int w;
    cmd_t c;
    logic [31:0] rd;
    logic rc;
    if (fill0 && !pend[0]) begin rand_cmd(pend_cmd[0]); pend[0] = 1'b1; end
    if (fill1 && !pend[1]) begin rand_cmd(pend_cmd[1]); pend[1] = 1'b1; end
    if (!pend[0] && !pend[1]) begin
      w = int'($urandom_range(0, 1));
      rand_cmd(pend_cmd[w]);
      pend[w] = 1'b1;
    end
    drive_reqs();
    #1;
    if (pend[0] && pend[1]) w = (last_win == 0) ? 1 : 0;
    else                    w = pend[0] ? 0 : 1;
    check_eq("grant_rdy", {req0_ready, req1_ready}, (w == 0) ? 2'b10 : 2'b01);
    c = pend_cmd[w];
    rd = fixed_rsp ? rsp_d : $urandom;
    rc = fixed_rsp ? rsp_c : 1'($urandom);
    @(posedge clk);
    @(negedge clk);
    pend[w] = 1'b0;
    last_win = w;
    grant_log.push_back(w);
    drive_reqs();
    for (int i = 1; i <= k; i++) begin
      if (i > 1) @(negedge clk);
      check_busy(c);
      if (i == k) begin
        fpu_valid = 1'b1;
        fpu_out_data = rd;
        fpu_cond = rc;
      end
    end
    @(negedge clk);
    fpu_valid = 1'b0;
    fpu_out_data = $urandom;
    fpu_cond = 1'($urandom);
    check_eq("resp_fpu_ready", fpu_ready, 1'b0);
    check_eq("resp_vld", {resp0_valid, resp1_valid}, (w == 0) ? 2'b10 : 2'b01);
    check_eq("resp_data", resp_data, rd);
    check_eq("resp_cond", resp_cond, rc);
    check_eq("resp_err", resp_err, 1'b0);
    check_eq("resp_rdy", {req0_ready, req1_ready}, 2'b00);
    exp_data = rd;
    exp_cond = rc;
    @(negedge clk);
    check_eq("post_resp_vld", {resp0_valid, resp1_valid}, 2'b00);
    check_eq("post_resp_hold", {resp_data, resp_cond}, {exp_data, exp_cond});
  endtask

  // Stray fpu_valid while idle must not produce a response.
  task automatic idle_junk();
    drive_reqs();
    fpu_valid = 1'b1;
    fpu_out_data = $urandom;
    @(negedge clk);
    fpu_valid = 1'b0;
    check_eq("idle_fpu_ready", fpu_ready, 1'b0);
    check_eq("idle_resp_vld", {resp0_valid, resp1_valid}, 2'b00);
    check_eq("idle_resp_hold", resp_data, exp_data);
  endtask

  task automatic drain();
    while (pend[0] || pend[1]) one_cmd(2, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
  endtask

`ifdef FPU_ARB_TIMEOUT_EN
  task automatic tmo_cmd(input bit respond);
    logic [31:0] rd;
    rd = $urandom;
    rand_cmd(pend_cmd[0]);
    pend[0] = 1'b1;
    drive_reqs();
    #1;
    check_eq("tmo_grant", {req0_ready, req1_ready}, 2'b10);
    @(posedge clk);
    @(negedge clk);
    pend[0] = 1'b0;
    last_win = 0;
    drive_reqs();
    for (int i = 1; i <= 8; i++) begin
      if (i > 1) @(negedge clk);
      check_eq("tmo_busy_ready", fpu_ready, 1'b1);
      if (i == 8 && respond) begin
        fpu_valid = 1'b1;
        fpu_out_data = rd;
        fpu_cond = 1'b1;
      end
    end
    @(negedge clk);
    fpu_valid = 1'b0;
    check_eq("tmo_fpu_ready", fpu_ready, 1'b0);
    check_eq("tmo_resp_vld", {resp0_valid, resp1_valid}, 2'b10);
    check_eq("tmo_resp_err", resp_err, !respond);
    check_eq("tmo_resp_data", {resp_data, resp_cond}, respond ? {rd, 1'b1} : 33'h0);
    exp_data = respond ? rd : 32'h0;
    @(negedge clk);
    check_eq("tmo_post_vld", {resp0_valid, resp1_valid}, 2'b00);
    check_eq("tmo_err_hold", resp_err, !respond);
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    rst = 1'b1;
    fpu_valid = 1'b0;
    fpu_out_data = '0;
    fpu_cond = 1'b0;
    pend[0] = 1'b0;
    pend[1] = 1'b0;
    pend_cmd[0] = '0;
    pend_cmd[1] = '0;
    drive_reqs();
    last_win = 1;
    exp_data = '0;
    exp_cond = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("rst_fpu_ready", fpu_ready, 1'b0);
    check_eq("rst_resp_vld", {resp0_valid, resp1_valid, resp_err}, 3'b000);
    check_eq("rst_resp_data", {resp_data, resp_cond}, 33'h0);
    check_eq("rst_fpu_cmd", {fpu_operation, fpu_x1, fpu_x2, fpu_y, fpu_in_data}, 53'h0);
    rst = 1'b0;
    @(negedge clk);

    // Contention straight after reset: req0 first, then strict alternation.
    base = grant_log.size();
    repeat (4) one_cmd(2, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 4; i++) check_eq("rr_order", grant_log[base + i], i % 2);
    drain();

    pend_cmd[0] = {OP_SET, 5'd0, 5'd0, 5'd1, 32'h3f800000};
    pend[0] = 1'b1;
    one_cmd(3, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);

    pend_cmd[1] = {OP_FADD, 5'd0, 5'd1, 5'd2, 32'h0};
    pend[1] = 1'b1;
    one_cmd(4, 1'b0, 1'b0, 1'b1, 32'h40000000, 1'b1);

    // Reset two cycles into a command: dropped silently.
    rand_cmd(pend_cmd[1]);
    pend[1] = 1'b1;
    drive_reqs();
    @(posedge clk);
    @(negedge clk);
    pend[1] = 1'b0;
    drive_reqs();
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_eq("midrst_fpu_ready", fpu_ready, 1'b0);
    check_eq("midrst_resp_vld", {resp0_valid, resp1_valid}, 2'b00);
    check_eq("midrst_resp_data", resp_data, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    last_win = 1;
    exp_data = '0;
    exp_cond = 1'b0;
    @(negedge clk);
    check_eq("postrst_resp_vld", {resp0_valid, resp1_valid}, 2'b00);
    one_cmd(2, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0);

    for (int n = 0; n < 60; n++) begin
      if (!pend[0] && !pend[1] && ($urandom_range(0, 3) == 0)) idle_junk();
      one_cmd(int'($urandom_range(1, 6)), 1'($urandom), 1'($urandom), 1'b0, 32'h0, 1'b0);
    end
    drain();

`ifdef FPU_ARB_TIMEOUT_EN
    tmo_cmd(1'b0);
    tmo_cmd(1'b1);
    one_cmd(8, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
`else
    one_cmd(40, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
